// File: rtl/sram_wrapper.sv
// sram_wrapper: AXI-style slave that bridges one read or one write
// transaction at a time onto a single-port synchronous SRAM.
//
// Optional feature macro: SRAM_WRAPPER_BURST_EN
//   defined   -> INCR bursts of 1-16 beats (ARLEN/AWLEN honoured)
//   undefined -> every transaction is single-beat, RLAST=1 on every read
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   AR* (in) / ARREADY (out)         read-address channel
//   R*  (out) / RREADY (in)          read-data channel
//   AW* (in) / AWREADY (out)         write-address channel
//   W*  (in) / WREADY (out)          write-data channel
//   B*  (out) / BREADY (in)          write-response channel
//   CEB, WEB, A, DI (out), DO (in)   SRAM port; DO is valid the cycle
//                                    after a read access
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for AW or AR; AW wins when both are valid
// RD_ACC  | SRAM read access for the current word address
// RD_DATA | R beat presented; waits for RREADY
// WR_DATA | accepting W beats, one SRAM write per W handshake
// WR_RESP | B response presented; waits for BREADY
module sram_wrapper #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  // read address
  input  logic [7:0]        ARID,
  input  logic [31:0]       ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  // read data
  output logic [7:0]        RID,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  // write address
  input  logic [7:0]        AWID,
  input  logic [31:0]       AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  // write data
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  // write response
  output logic [7:0]        BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  // SRAM
  output logic              CEB,
  output logic [3:0]        WEB,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       DI,
  input  logic [31:0]       DO
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ACC  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t            state_q, state_d;
  logic [7:0]        id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;     // beats remaining after the current one
  logic [31:0]       rdata_q, rdata_d;
  logic              rd_first_q, rd_first_d;
  logic [1:0]        bresp_q, bresp_d;

  // Size/burst type are ignored (always 32-bit INCR) and the byte-offset and
  // above-range address bits carry no information for a word SRAM.
  logic unused_inputs;
  assign unused_inputs = ^{ARSIZE, ARBURST, AWSIZE, AWBURST,
                           ARADDR[31:ADDR_W+2], ARADDR[1:0],
                           AWADDR[31:ADDR_W+2], AWADDR[1:0]
`ifndef SRAM_WRAPPER_BURST_EN
                           , ARLEN, AWLEN
`endif
                           };

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      rdata_q    <= '0;
      rd_first_q <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      rdata_q    <= rdata_d;
      rd_first_q <= rd_first_d;
      bresp_q    <= bresp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    rdata_d    = rdata_q;
    rd_first_d = 1'b0;
    bresp_d    = bresp_q;

    ARREADY = 1'b0;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    BVALID  = 1'b0;
    CEB     = 1'b1;
    WEB     = 4'hF;
    A       = '0;
    DI      = '0;

    unique case (state_q)
      IDLE: begin
        AWREADY = 1'b1;
        ARREADY = ~AWVALID;
        if (AWVALID) begin
          id_d    = AWID;
          addr_d  = AWADDR[ADDR_W+1:2];
`ifdef SRAM_WRAPPER_BURST_EN
          len_d   = AWLEN;
`else
          len_d   = '0;
`endif
          bresp_d = RESP_OKAY;
          state_d = WR_DATA;
        end else if (ARVALID) begin
          id_d    = ARID;
          addr_d  = ARADDR[ADDR_W+1:2];
`ifdef SRAM_WRAPPER_BURST_EN
          len_d   = ARLEN;
`else
          len_d   = '0;
`endif
          state_d = RD_ACC;
        end
      end

      RD_ACC: begin
        CEB        = 1'b0;
        A          = addr_q;
        rd_first_d = 1'b1;
        state_d    = RD_DATA;
      end

      RD_DATA: begin
        RVALID = 1'b1;
        RLAST  = (len_q == 4'd0);
        // DO is only guaranteed in the first RD_DATA cycle; capture it so the
        // beat stays stable through an RREADY stall.
        if (rd_first_q) rdata_d = DO;
        if (RREADY) begin
          if (len_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            len_d   = len_q - 4'd1;
            addr_d  = addr_q + 1'b1;
            state_d = RD_ACC;
          end
        end
      end

      WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          CEB    = 1'b0;
          WEB    = ~WSTRB;
          A      = addr_q;
          DI     = WDATA;
          addr_d = addr_q + 1'b1;
          // An early WLAST truncates the burst; a missing one is flagged but
          // the burst still ends on the counted beat.
          if (WLAST || (len_q == 4'd0)) begin
            bresp_d = (WLAST && (len_q == 4'd0)) ? RESP_OKAY : RESP_SLVERR;
            state_d = WR_RESP;
          end else begin
            len_d = len_q - 4'd1;
          end
        end
      end

      WR_RESP: begin
        BVALID = 1'b1;
        if (BREADY) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    RID   = id_q;
    BID   = id_q;
    BRESP = bresp_q;
    RRESP = RESP_OKAY;
    RDATA = rd_first_q ? DO : rdata_q;

    // Reset is synchronous for the registers, but the handshake outputs are
    // also masked combinationally so nothing is offered while rst is high.
    if (rst) begin
      ARREADY = 1'b0;
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      RVALID  = 1'b0;
      RLAST   = 1'b0;
      BVALID  = 1'b0;
      CEB     = 1'b1;
      WEB     = 4'hF;
      A       = '0;
      DI      = '0;
      RID     = '0;
      BID     = '0;
      BRESP   = RESP_OKAY;
      RDATA   = '0;
    end
  end

endmodule

// File: tb/tb_sram_wrapper.sv
module tb_sram_wrapper;

  localparam int AW_W = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      ARID;
  logic [31:0]     ARADDR;
  logic [3:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARVALID, ARREADY;
  logic [7:0]      RID;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST, RVALID, RREADY;
  logic [7:0]      AWID;
  logic [31:0]     AWADDR;
  logic [3:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID, AWREADY;
  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WLAST, WVALID, WREADY;
  logic [7:0]      BID;
  logic [1:0]      BRESP;
  logic            BVALID, BREADY;
  logic            CEB;
  logic [3:0]      WEB;
  logic [AW_W-1:0] A;
  logic [31:0]     DI;
  logic [31:0]     DO;

  sram_wrapper #(.ADDR_W(AW_W)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: word i starts as C0DE_iiii. DO carries junk whenever the
  // previous cycle was not a read, so a wrapper that does not hold its
  // captured read data is exposed.
  logic [31:0] mem [0:(1<<AW_W)-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << AW_W); i++) mem[i] <= {16'hC0DE, 16'(i)};
      DO <= 32'hBAD0_0000;
    end else if (!CEB && WEB == 4'hF) begin
      DO <= mem[A];
    end else begin
      DO <= 32'hBAD0_0000 + 32'(cyc);
      if (!CEB)
        for (int b = 0; b < 4; b++)
          if (!WEB[b]) mem[A][b*8 +: 8] <= DI[b*8 +: 8];
    end
  end

  typedef struct packed {logic [7:0] id; logic [31:0] data; logic last;} r_t;
  typedef struct packed {logic [AW_W-1:0] a; logic [3:0] web; logic [31:0] di;} w_t;
  typedef struct packed {logic [7:0] id; logic [1:0] resp;} b_t;

  r_t              exp_r[$];
  w_t              exp_w[$];
  b_t              exp_b[$];
  logic [AW_W-1:0] exp_ra[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_r(input logic [7:0] id, input logic [31:0] d, input logic l);
    r_t x;
    x.id = id; x.data = d; x.last = l;
    exp_r.push_back(x);
  endtask

  task automatic push_w(input logic [AW_W-1:0] a, input logic [3:0] web, input logic [31:0] d);
    w_t x;
    x.a = a; x.web = web; x.di = d;
    exp_w.push_back(x);
  endtask

  task automatic push_b(input logic [7:0] id, input logic [1:0] resp);
    b_t x;
    x.id = id; x.resp = resp;
    exp_b.push_back(x);
  endtask

  // Monitor: pops an expectation whenever the DUT presents a transfer.
  r_t              mr;
  w_t              mw;
  b_t              mb;
  logic [AW_W-1:0] ma;
  always @(negedge clk) begin
    if (!rst) begin
      if (!CEB && WEB == 4'hF) begin
        if (exp_ra.size() == 0) begin
          checks++; errors++;
          $display("FAIL sram_rd_access: got read at A=%h expected no access", A);
        end else begin
          ma = exp_ra.pop_front();
          chk("sram_rd_addr", 32'(A), 32'(ma));
        end
      end else if (!CEB) begin
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL sram_wr_access: got write at A=%h expected no access", A);
        end else begin
          mw = exp_w.pop_front();
          chk("sram_wr_addr", 32'(A), 32'(mw.a));
          chk("sram_wr_web", 32'(WEB), 32'(mw.web));
          chk("sram_wr_di", DI, mw.di);
        end
      end
      if (RVALID && RREADY) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_beat: got beat RID=%h RDATA=%h expected none", RID, RDATA);
        end else begin
          mr = exp_r.pop_front();
          chk("r_id", 32'(RID), 32'(mr.id));
          chk("r_data", RDATA, mr.data);
          chk("r_last", 32'(RLAST), 32'(mr.last));
          chk("r_resp", 32'(RRESP), 32'd0);
        end
      end
      if (BVALID && BREADY) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_resp: got BID=%h BRESP=%h expected none", BID, BRESP);
        end else begin
          mb = exp_b.pop_front();
          chk("b_id", 32'(BID), 32'(mb.id));
          chk("b_resp", 32'(BRESP), 32'(mb.resp));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // All driver tasks are entered just after a rising edge.
  task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n;
    n = 0;
    ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    @(negedge clk);
    while (!ARREADY && n < 50) begin @(negedge clk); n++; end
    if (!ARREADY) begin
      checks++; errors++;
      $display("FAIL ar_handshake: got ARREADY=0 for 50 cycles expected 1");
    end
    tick();
    ARVALID = 1'b0;
  endtask

  task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n;
    n = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    @(negedge clk);
    while (!AWREADY && n < 50) begin @(negedge clk); n++; end
    if (!AWREADY) begin
      checks++; errors++;
      $display("FAIL aw_handshake: got AWREADY=0 for 50 cycles expected 1");
    end
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
    int n;
    n = 0;
    WDATA = d; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    @(negedge clk);
    while (!WREADY && n < 50) begin @(negedge clk); n++; end
    if (!WREADY) begin
      checks++; errors++;
      $display("FAIL w_handshake: got WREADY=0 for 50 cycles expected 1");
    end
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by 400us expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int n;
    rst = 1'b1;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    RREADY = 1'b1; BREADY = 1'b1;
    repeat (3) tick();

    // reset state
    @(negedge clk);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_wready", 32'(WREADY), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_ceb", 32'(CEB), 32'd1);
    chk("rst_web", 32'(WEB), 32'hF);
    chk("rst_a", 32'(A), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", 32'(ARREADY), 32'd1);
    chk("post_rst_awready", 32'(AWREADY), 32'd1);
    tick();

    // single read at 0x10: access in T+1, beat in T+2
    exp_ra.push_back(14'h0004);
    push_r(8'h5A, 32'hC0DE_0004, 1'b1);
    do_ar(8'h5A, 32'h0000_0010, 4'd0);
    @(negedge clk);
    chk("t1_ceb_T1", 32'(CEB), 32'd0);
    chk("t1_a_T1", 32'(A), 32'd4);
    chk("t1_rvalid_T1", 32'(RVALID), 32'd0);
    @(negedge clk);
    chk("t1_rvalid_T2", 32'(RVALID), 32'd1);
    chk("t1_rlast_T2", 32'(RLAST), 32'd1);
    repeat (3) tick();

    // write at 0x20 with WSTRB=0011, then read back
`ifdef SRAM_WRAPPER_BURST_EN
    push_w(14'd8,  4'hC, 32'h1111_AAAA);
    push_w(14'd9,  4'hC, 32'h2222_BBBB);
    push_w(14'd10, 4'hC, 32'h3333_CCCC);
    push_w(14'd11, 4'hC, 32'h4444_DDDD);
    push_b(8'h33, 2'b00);
    do_aw(8'h33, 32'h0000_0020, 4'd3);
    do_w(32'h1111_AAAA, 4'b0011, 1'b0);
    do_w(32'h2222_BBBB, 4'b0011, 1'b0);
    do_w(32'h3333_CCCC, 4'b0011, 1'b0);
    do_w(32'h4444_DDDD, 4'b0011, 1'b1);
`else
    push_w(14'd8, 4'hC, 32'h1111_AAAA);
    push_b(8'h33, 2'b10);
    do_aw(8'h33, 32'h0000_0020, 4'd3);
    do_w(32'h1111_AAAA, 4'b0011, 1'b0);
`endif
    @(negedge clk);
    chk("t2_bvalid", 32'(BVALID), 32'd1);
    repeat (2) tick();
`ifdef SRAM_WRAPPER_BURST_EN
    exp_ra.push_back(14'd8); exp_ra.push_back(14'd9);
    exp_ra.push_back(14'd10); exp_ra.push_back(14'd11);
    push_r(8'h34, 32'hC0DE_AAAA, 1'b0);
    push_r(8'h34, 32'hC0DE_BBBB, 1'b0);
    push_r(8'h34, 32'hC0DE_CCCC, 1'b0);
    push_r(8'h34, 32'hC0DE_DDDD, 1'b1);
`else
    exp_ra.push_back(14'd8);
    push_r(8'h34, 32'hC0DE_AAAA, 1'b1);
`endif
    ARBURST = 2'b00;
    do_ar(8'h34, 32'h0000_0020, 4'd3);
    ARBURST = 2'b01;
    repeat (10) tick();

    // AR and AW together: write first, read held off until B completes
    ARID = 8'h11; ARADDR = 32'h0000_0030; ARLEN = 4'd0; ARVALID = 1'b1;
    AWID = 8'h22; AWADDR = 32'h0000_0040; AWLEN = 4'd0; AWVALID = 1'b1;
    push_w(14'h0010, 4'h0, 32'hDEAD_BEEF);
    push_b(8'h22, 2'b00);
    exp_ra.push_back(14'h000C);
    push_r(8'h11, 32'hC0DE_000C, 1'b1);
    @(negedge clk);
    chk("t3_awready", 32'(AWREADY), 32'd1);
    chk("t3_arready_blocked", 32'(ARREADY), 32'd0);
    tick();
    AWVALID = 1'b0;
    @(negedge clk);
    chk("t3_arready_wr", 32'(ARREADY), 32'd0);
    chk("t3_wready", 32'(WREADY), 32'd1);
    tick();
    BREADY = 1'b0;
    do_w(32'hDEAD_BEEF, 4'hF, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t3_bvalid_hold", 32'(BVALID), 32'd1);
      chk("t3_arready_resp", 32'(ARREADY), 32'd0);
    end
    tick();
    BREADY = 1'b1;
    @(negedge clk);
    chk("t3_arready_bhs", 32'(ARREADY), 32'd0);
    @(negedge clk);
    chk("t3_arready_after_b", 32'(ARREADY), 32'd1);
    tick();
    ARVALID = 1'b0;
    repeat (4) tick();

    // read stall for 5 cycles
    RREADY = 1'b0;
    exp_ra.push_back(14'd5);
    push_r(8'h44, 32'hC0DE_0005, 1'b1);
    do_ar(8'h44, 32'h0000_0014, 4'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_rvalid", 32'(RVALID), 32'd1);
    chk("t4_rdata", RDATA, 32'hC0DE_0005);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_stall_rvalid", 32'(RVALID), 32'd1);
      chk("t4_stall_rdata", RDATA, 32'hC0DE_0005);
      chk("t4_stall_rid", 32'(RID), 32'h44);
      chk("t4_stall_ceb", 32'(CEB), 32'd1);
    end
    tick();
    RREADY = 1'b1;
    repeat (3) tick();

    // early WLAST (burst) / single beat with WLAST
`ifdef SRAM_WRAPPER_BURST_EN
    push_w(14'h0014, 4'h0, 32'h5555_0001);
    push_w(14'h0015, 4'h0, 32'h5555_0002);
    push_b(8'h55, 2'b10);
    do_aw(8'h55, 32'h0000_0050, 4'd3);
    do_w(32'h5555_0001, 4'hF, 1'b0);
    do_w(32'h5555_0002, 4'hF, 1'b1);
`else
    push_w(14'h0014, 4'h0, 32'h5555_0001);
    push_b(8'h55, 2'b00);
    do_aw(8'h55, 32'h0000_0050, 4'd3);
    do_w(32'h5555_0001, 4'hF, 1'b1);
`endif
    @(negedge clk);
    chk("t5_wready_after_end", 32'(WREADY), 32'd0);
    chk("t5_bvalid", 32'(BVALID), 32'd1);
    repeat (3) tick();

    // reset during a read beat (third beat of a 4-beat burst)
    got = 0;
    n = 0;
`ifdef SRAM_WRAPPER_BURST_EN
    exp_ra.push_back(14'd0); exp_ra.push_back(14'd1); exp_ra.push_back(14'd2);
    push_r(8'h66, 32'hC0DE_0000, 1'b0);
    push_r(8'h66, 32'hC0DE_0001, 1'b0);
    RREADY = 1'b1;
    do_ar(8'h66, 32'h0000_0000, 4'd3);
    while (got < 2 && n < 40) begin
      @(negedge clk);
      if (RVALID && RREADY) got++;
      n++;
    end
    chk("t6_pre_beats", 32'(got), 32'd2);
    tick();
    RREADY = 1'b0;
`else
    exp_ra.push_back(14'd0);
    RREADY = 1'b0;
    do_ar(8'h66, 32'h0000_0000, 4'd3);
`endif
    n = 0;
    @(negedge clk);
    while (!RVALID && n < 10) begin @(negedge clk); n++; end
    chk("t6_beat_valid", 32'(RVALID), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rvalid_in_rst", 32'(RVALID), 32'd0);
    tick();
    RREADY = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_arready_after_rst", 32'(ARREADY), 32'd1);
    chk("t6_rvalid_after_rst", 32'(RVALID), 32'd0);
    repeat (6) tick();
    chk("t6_r_queue_drained", 32'(exp_r.size()), 32'd0);

    // address wrap at the top of the SRAM
`ifdef SRAM_WRAPPER_BURST_EN
    push_w(14'h3FFF, 4'h0, 32'h7777_0001);
    push_w(14'h0000, 4'h0, 32'h7777_0002);
    push_b(8'h77, 2'b00);
    do_aw(8'h77, 32'h0001_FFFC, 4'd1);
    do_w(32'h7777_0001, 4'hF, 1'b0);
    do_w(32'h7777_0002, 4'hF, 1'b1);
    repeat (3) tick();
    exp_ra.push_back(14'h3FFF); exp_ra.push_back(14'h0000);
    push_r(8'h78, 32'h7777_0001, 1'b0);
    push_r(8'h78, 32'h7777_0002, 1'b1);
    do_ar(8'h78, 32'hABCD_FFFC, 4'd1);
`else
    push_w(14'h3FFF, 4'h0, 32'h7777_0001);
    push_b(8'h77, 2'b00);
    do_aw(8'h77, 32'h0001_FFFC, 4'd1);
    do_w(32'h7777_0001, 4'hF, 1'b1);
    repeat (3) tick();
    exp_ra.push_back(14'h3FFF);
    push_r(8'h78, 32'h7777_0001, 1'b1);
    do_ar(8'h78, 32'hABCD_FFFC, 4'd1);
`endif
    repeat (8) tick();

    chk("end_r_queue", 32'(exp_r.size()), 32'd0);
    chk("end_w_queue", 32'(exp_w.size()), 32'd0);
    chk("end_b_queue", 32'(exp_b.size()), 32'd0);
    chk("end_ra_queue", 32'(exp_ra.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
